instr_fetch: RTL and testbench

//  Instruction fetch stage of the RISC-V core. Consumes the PC register's current

---
 rtl/instr_fetch.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, PC update on grant, IF/ID FIFO to decode.
// Head is valid 1 cycle after rvalid; fetching pauses while the FIFO is full and resumes on id_ready pop.
module instr_fetch #(
  parameter int FIFO_DEPTH = 2,
  parameter int PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL_REQ,
    S_KILL_WAIT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [31:0]     r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];

  logic [31:0]     w_redirect_pc;
  logic [31:0]     w_seq_pc;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_next;
  logic            w_unused;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];
  assign w_seq_pc      = imem_addr + 32'(PC_STEP);

  assign if_valid = (r_count != '0);
  assign if_pc    = r_fifo_pc[r_rd_ptr];
  assign if_instr = r_fifo_instr[r_rd_ptr];

  // A redirect flushes the buffer, so it masks both the push and the pop of that cycle.
  assign w_push       = (r_state == S_WAIT) && imem_rvalid && !redirect;
  assign w_pop        = if_valid && id_ready && !redirect;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    pc_write = 1'b0;
    next_pc  = '0;
    if (!res) begin
      pc_write = 1'b0;
      next_pc  = '0;
    end else if (redirect) begin
      pc_write = 1'b1;
      next_pc  = w_redirect_pc;
    end else if ((r_state == S_REQ) && imem_gnt) begin
      pc_write = 1'b1;
      next_pc  = w_seq_pc;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state   <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!redirect && (r_count < DEPTH_C)) begin
            r_state   <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
          end
        end
        S_REQ: begin
          if (imem_gnt) begin
            imem_req <= 1'b0;
            r_state  <= redirect ? S_KILL_WAIT : S_WAIT;
          end else if (redirect) begin
            r_state <= S_KILL_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              r_state <= S_IDLE;
            end else if (w_count_next < DEPTH_C) begin
              r_state   <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc_in;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (redirect) begin
            r_state <= S_KILL_WAIT;
          end
        end
        // Killed transactions still complete on the bus; their data is never buffered.
        S_KILL_REQ: begin
          if (imem_gnt) begin
            imem_req <= 1'b0;
            r_state  <= S_KILL_WAIT;
          end
        end
        S_KILL_WAIT: begin
          if (imem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (redirect) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= imem_addr;
        r_fifo_instr[r_wr_ptr] <= imem_rdata;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written reset/flush sequences,
// then randomized memory/decode/redirect traffic against a transaction-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] pc_in;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  always #5 clk = ~clk;

  instr_fetch #(.FIFO_DEPTH(2), .PC_STEP(4)) dut (
    .clk(clk), .res(res), .pc_in(pc_in), .pc_write(pc_write), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Acts as the PC register: captures next_pc at the clock edge, visible just after it.
  task automatic advance();
    logic        w;
    logic [31:0] n;
    w = pc_write;
    n = next_pc;
    @(posedge clk);
    #1;
    if (w) pc_in = n;
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] rdpc;
    logic        idr;
    logic        pcw;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] iinstr;
  } vec_t;

  function automatic vec_t mk(logic g, logic r, logic [31:0] d, logic rd, logic [31:0] rp,
                              logic ir, logic pw, logic [31:0] np, logic rq, logic [31:0] ad,
                              logic v, logic [31:0] ip, logic [31:0] ii);
    vec_t t;
    t.gnt = g;  t.rv = r;   t.rdata = d; t.rd = rd; t.rdpc = rp; t.idr = ir;
    t.pcw = pw; t.npc = np; t.req = rq;  t.addr = ad; t.vld = v; t.ipc = ip; t.iinstr = ii;
    return t;
  endfunction

  localparam int NV = 22;
  vec_t vt [NV];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_inflight;
  logic        m_granted;
  logic        m_killed;
  logic [31:0] q_pc [$];
  logic [31:0] q_ins [$];
  int          pops;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // gnt rv rdata rd rdpc idr | pcw npc req addr vld ipc instr
    vt[0]  = mk(1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 32'h0);
    vt[1]  = mk(1, 0, 32'h0,        0, 32'h0,   0, 1, 32'h4,   1, 32'h0,   0, 32'h0, 32'h0);
    vt[2]  = mk(1, 1, 32'h00500093, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 32'h0);
    vt[3]  = mk(1, 1, 32'hDEADBEEF, 0, 32'h0,   0, 1, 32'h8,   1, 32'h4,   1, 32'h0, 32'h00500093);
    vt[4]  = mk(1, 1, 32'h00A00113, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4,   1, 32'h0, 32'h00500093);
    vt[5]  = mk(1, 1, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 32'h4,   1, 32'h0, 32'h00500093);
    vt[6]  = mk(1, 1, 32'h0,        0, 32'h0,   1, 0, 32'h0,   0, 32'h4,   1, 32'h0, 32'h00500093);
    vt[7]  = mk(1, 1, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 32'h4,   1, 32'h4, 32'h00A00113);
    vt[8]  = mk(1, 0, 32'h0,        0, 32'h0,   0, 1, 32'hC,   1, 32'h8,   1, 32'h4, 32'h00A00113);
    vt[9]  = mk(1, 1, 32'h00208193, 0, 32'h0,   1, 0, 32'h0,   0, 32'h8,   1, 32'h4, 32'h00A00113);
    vt[10] = mk(0, 0, 32'h0,        0, 32'h0,   1, 0, 32'h0,   1, 32'hC,   1, 32'h8, 32'h00208193);
    vt[11] = mk(1, 0, 32'h0,        0, 32'h0,   0, 1, 32'h10,  1, 32'hC,   0, 32'h0, 32'h0);
    vt[12] = mk(0, 0, 32'h0,        1, 32'h100, 0, 1, 32'h100, 0, 32'hC,   0, 32'h0, 32'h0);
    vt[13] = mk(0, 1, 32'hBAD0BAD0, 0, 32'h0,   0, 0, 32'h0,   0, 32'hC,   0, 32'h0, 32'h0);
    vt[14] = mk(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 32'hC,   0, 32'h0, 32'h0);
    vt[15] = mk(0, 0, 32'h0,        1, 32'h203, 0, 1, 32'h200, 1, 32'h100, 0, 32'h0, 32'h0);
    vt[16] = mk(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h0, 32'h0);
    vt[17] = mk(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h0, 32'h0);
    vt[18] = mk(1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h0, 32'h0);
    vt[19] = mk(0, 1, 32'hBADBAD00, 0, 32'h0,   0, 0, 32'h0,   0, 32'h100, 0, 32'h0, 32'h0);
    vt[20] = mk(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 32'h100, 0, 32'h0, 32'h0);
    vt[21] = mk(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   1, 32'h200, 0, 32'h0, 32'h0);

    // Reset state; a redirect during reset must not write the PC.
    res = 1'b0; pc_in = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b1; redirect_pc = 32'h40; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst.next_pc", next_pc, 32'h0);
    chk("rst.imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst.imem_addr", imem_addr, 32'h0);
    chk("rst.if_valid", {31'd0, if_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    res = 1'b1;

    for (int i = 0; i < NV; i++) begin
      imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rv; imem_rdata = vt[i].rdata;
      redirect = vt[i].rd;  redirect_pc = vt[i].rdpc; id_ready = vt[i].idr;
      @(negedge clk);
      chk($sformatf("v%0d.pc_write", i), {31'd0, pc_write}, {31'd0, vt[i].pcw});
      if (vt[i].pcw) chk($sformatf("v%0d.next_pc", i), next_pc, vt[i].npc);
      chk($sformatf("v%0d.imem_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
      chk($sformatf("v%0d.imem_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d.if_valid", i), {31'd0, if_valid}, {31'd0, vt[i].vld});
      if (vt[i].vld) begin
        chk($sformatf("v%0d.if_pc", i), if_pc, vt[i].ipc);
        chk($sformatf("v%0d.if_instr", i), if_instr, vt[i].iinstr);
      end
      advance();
    end

    // Fill both entries, then redirect + rvalid + pop in the same cycle.
    imem_gnt = 1'b1; imem_rvalid = 1'b1; redirect = 1'b0; id_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      imem_rdata = 32'h1000_0000 + 32'(k);
      @(negedge clk);
      advance();
    end
    @(negedge clk);
    chk("full.imem_req", {31'd0, imem_req}, 32'd0);
    chk("full.if_valid", {31'd0, if_valid}, 32'd1);
    chk("full.if_pc", if_pc, 32'h200);
    advance();
    redirect = 1'b1; redirect_pc = 32'h3000; id_ready = 1'b1;
    @(negedge clk);
    chk("flush.pc_write", {31'd0, pc_write}, 32'd1);
    chk("flush.next_pc", next_pc, 32'h3000);
    advance();
    redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    chk("flush.if_valid", {31'd0, if_valid}, 32'd0);
    chk("flush.imem_req", {31'd0, imem_req}, 32'd0);
    advance();
    @(negedge clk);
    chk("flush.req_after", {31'd0, imem_req}, 32'd1);
    chk("flush.addr_after", imem_addr, 32'h3000);
    advance();

    // Async reset asserted between edges while waiting on memory.
    imem_gnt = 1'b1;
    @(negedge clk); advance();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0011;
    @(negedge clk); advance();
    imem_gnt = 1'b1; imem_rvalid = 1'b0;
    @(negedge clk); advance();
    imem_gnt = 1'b0;
    #2;
    chk("arst.pre_if_valid", {31'd0, if_valid}, 32'd1);
    res = 1'b0;
    #1;
    chk("arst.if_valid", {31'd0, if_valid}, 32'd0);
    chk("arst.imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst.pc_write", {31'd0, pc_write}, 32'd0);
    chk("arst.imem_addr", imem_addr, 32'h0);
    pc_in = 32'h4440;
    advance();
    res = 1'b1;
    @(negedge clk);
    chk("arst.idle_req", {31'd0, imem_req}, 32'd0);
    advance();
    @(negedge clk);
    chk("arst.restart_req", {31'd0, imem_req}, 32'd1);
    chk("arst.restart_addr", imem_addr, 32'h4440);
    advance();

    // Randomized traffic against the transaction-level model.
    res = 1'b0;
    advance();
    pc_in = 32'hFFFF_FFE0;
    res = 1'b1;
    m_pc = pc_in; m_addr = 32'h0; m_inflight = 1'b0; m_granted = 1'b0; m_killed = 1'b0;
    pops = 0;
    for (int c = 0; c < 4000; c++) begin
      logic        e_pcw;
      logic [31:0] e_npc;
      logic [31:0] rp;
      imem_gnt    = ($urandom_range(0, 99) < 60);
      imem_rvalid = m_granted ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 8);
      imem_rdata  = $urandom;
      redirect    = ($urandom_range(0, 99) < 5);
      rp          = $urandom;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFFC | {30'd0, rp[1:0]};
      redirect_pc = rp;
      id_ready    = ($urandom_range(0, 99) < 55);
      @(negedge clk);

      chk("rnd.if_valid", {31'd0, if_valid}, {31'd0, (q_pc.size() != 0)});
      if (q_pc.size() != 0) begin
        chk("rnd.if_pc", if_pc, q_pc[0]);
        chk("rnd.if_instr", if_instr, q_ins[0]);
      end
      if (!m_inflight && imem_req) begin
        m_inflight = 1'b1; m_granted = 1'b0; m_killed = 1'b0; m_addr = imem_addr;
        chk("rnd.req_addr", imem_addr, m_pc);
      end
      if (m_inflight && !m_granted) begin
        chk("rnd.req_held", {31'd0, imem_req}, 32'd1);
        chk("rnd.addr_stable", imem_addr, m_addr);
      end
      if (m_granted) chk("rnd.one_outstanding", {31'd0, imem_req}, 32'd0);

      e_pcw = 1'b0; e_npc = 32'h0;
      if (redirect) begin
        e_pcw = 1'b1; e_npc = {redirect_pc[31:2], 2'b00};
      end else if (m_inflight && !m_granted && imem_gnt && !m_killed) begin
        e_pcw = 1'b1; e_npc = m_addr + 32'd4;
      end
      chk("rnd.pc_write", {31'd0, pc_write}, {31'd0, e_pcw});
      if (e_pcw) chk("rnd.next_pc", next_pc, e_npc);

      if (q_pc.size() != 0 && id_ready && !redirect) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
        pops++;
      end
      if (m_granted && imem_rvalid) begin
        if (!m_killed && !redirect) begin
          q_pc.push_back(m_addr);
          q_ins.push_back(imem_rdata);
        end
        m_inflight = 1'b0; m_granted = 1'b0;
      end else if (m_inflight && !m_granted && imem_gnt) begin
        m_granted = 1'b1;
        if (!redirect && !m_killed) m_pc = m_addr + 32'd4;
      end
      if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_inflight) m_killed = 1'b1;
        q_pc.delete();
        q_ins.delete();
      end
      chk("rnd.depth", 32'(q_pc.size()) <= 32'd2, 32'd1);
      advance();
    end
    chk("rnd.progress", {31'd0, (pops >= 100)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
